// File: rtl/display_channel_scheduler.sv
// Round-robin fetch of one signed reading per enabled sensor channel, held on data_o
// for a dwell period.  States: IDLE wait for any enable | REQ fetch ch_idx | SHOW dwell | NEXT pick channel.
module display_channel_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int DWELL_CYCLES   = 1000,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_CH-1:0]   en_i,
    input  logic [NUM_CH-1:0]   ch_valid_i,
    input  logic [8*NUM_CH-1:0] ch_data_i,
    input  logic                skip_i,
    output logic [NUM_CH-1:0]   ch_ready_o,
    output logic [7:0]          data_o,
    output logic                data_valid_o,
    output logic [1:0]          ch_idx_o,
    output logic [NUM_CH-1:0]   err_o
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_TC = DW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_TC   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SHOW, S_NEXT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [NUM_CH-1:0] ready_q, ready_d;
    logic [7:0]        data_q, data_d;
    logic              dvalid_q, dvalid_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic [NUM_CH-1:0] cur_oh;
    logic [7:0]        sel_data;
    logic              sel_en;
    logic              xfer;
    logic [1:0]        first_idx;
    logic [1:0]        next_idx;
    logic              next_found;

    function automatic logic [NUM_CH-1:0] onehot(input logic [1:0] i);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i == 2'(c)) v[c] = 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        cur_oh   = onehot(idx_q);
        sel_en   = |(en_i & cur_oh);
        xfer     = |(ready_q & ch_valid_i);
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cur_oh[c]) sel_data = ch_data_i[8*c +: 8];
        end
    end

    // Lowest enabled channel from IDLE; otherwise search upward from the current one, current last.
    always_comb begin
        first_idx  = '0;
        next_idx   = idx_q;
        next_found = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (en_i[c]) first_idx = 2'(c);
        end
        for (int off = 1; off <= NUM_CH; off++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!next_found && en_i[c] && (c == (int'(idx_q) + off) % NUM_CH)) begin
                    next_found = 1'b1;
                    next_idx   = 2'(c);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ready_d  = ready_q;
        data_d   = data_q;
        dvalid_d = dvalid_q;
        err_d    = err_q;
        dwell_d  = dwell_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (|en_i) begin
                    idx_d   = first_idx;
                    ready_d = onehot(first_idx);
                    tmo_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!sel_en) begin
                    ready_d = '0;
                    state_d = S_NEXT;
                end else if (xfer) begin
                    data_d   = sel_data;
                    err_d    = err_q & ~cur_oh;
                    dvalid_d = 1'b1;
                    ready_d  = '0;
                    dwell_d  = '0;
                    state_d  = S_SHOW;
                end else if (tmo_q == TMO_TC) begin
                    err_d   = err_q | cur_oh;
                    ready_d = '0;
                    state_d = S_NEXT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_SHOW: begin
                if (skip_i || (dwell_q == DWELL_TC)) begin
                    dvalid_d = 1'b0;
                    state_d  = S_NEXT;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (next_found) begin
                    idx_d   = next_idx;
                    ready_d = onehot(next_idx);
                    tmo_d   = '0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            ready_q  <= '0;
            data_q   <= 8'h00;
            dvalid_q <= 1'b0;
            err_q    <= '0;
            dwell_q  <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
            dwell_q  <= dwell_d;
            tmo_q    <= tmo_d;
        end
    end

    assign ch_ready_o   = ready_q;
    assign data_o       = data_q;
    assign data_valid_o = dvalid_q;
    assign ch_idx_o     = idx_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_display_channel_scheduler.sv
// Bench for display_channel_scheduler: table of channel visits plus hand sequences for
// mask-off, disabled-in-REQ and mid-SHOW reset; transfers are scored against a queue.
module tb_display_channel_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [3:0]  en_i = '0;
    logic [3:0]  ch_valid_i = '0;
    logic [31:0] ch_data_i = '0;
    logic        skip_i = 1'b0;
    logic [3:0]  ch_ready_o;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic [1:0]  ch_idx_o;
    logic [3:0]  err_o;

    display_channel_scheduler #(.NUM_CH(4), .DWELL_CYCLES(8), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .ch_valid_i(ch_valid_i),
        .ch_data_i(ch_data_i), .skip_i(skip_i), .ch_ready_o(ch_ready_o), .data_o(data_o),
        .data_valid_o(data_valid_o), .ch_idx_o(ch_idx_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] en;
        logic [3:0] valid;
        int         valid_at;
        bit         skip_req;
        int         skip_at;
        logic [1:0] exp_idx;
        logic [7:0] exp_data;
        int         exp_req;
        int         exp_len;
        int         exp_period;
        logic [3:0] exp_err;
    } row_t;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
        int         len;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    row_t rows[22];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_req_cyc = 0;
    int   show_len = 0;
    logic dv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    always @(posedge clk_i) cyc++;

    // Scoreboard: each rising data_valid_o pops one expected transfer; the fall checks the dwell.
    always @(negedge clk_i) begin
        if (data_valid_o && !dv_prev) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_xfer", 32'(ch_idx_o), 32'hFFFF_FFFF);
                cur.len = 0;
            end else begin
                cur = sb_q.pop_front();
                check("xfer_idx", 32'(ch_idx_o), 32'(cur.idx));
                check("xfer_data", 32'(data_o), 32'(cur.data));
            end
            show_len = 1;
        end else if (data_valid_o) begin
            show_len++;
        end else if (dv_prev && cur.len != 0) begin
            check("show_len", show_len, cur.len);
        end
        dv_prev = data_valid_o;
    end

    task automatic run_row(input row_t r, input int ri);
        int n;
        int req_n;
        int k;
        n = 0;
        while (ch_ready_o == '0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check($sformatf("row%0d_ready", ri), 32'(ch_ready_o), 32'(oh(r.exp_idx)));
        check($sformatf("row%0d_idx", ri), 32'(ch_idx_o), 32'(r.exp_idx));
        if (r.exp_period != 0) check($sformatf("row%0d_period", ri), cyc - last_req_cyc, r.exp_period);
        last_req_cyc = cyc;
        en_i       = r.en;
        ch_valid_i = r.valid;
        skip_i     = r.skip_req;
        if (r.exp_len != 0) sb_q.push_back('{r.exp_idx, r.exp_data, r.exp_len});
        req_n = 1;
        k = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk_i);
            if (ch_ready_o != '0) begin
                req_n++;
                if (req_n == r.valid_at) ch_valid_i = 4'hF;
            end else if (data_valid_o) begin
                k++;
                skip_i = (k == r.skip_at);
            end else begin
                break;
            end
        end
        skip_i = 1'b0;
        check($sformatf("row%0d_req_cycles", ri), req_n, r.exp_req);
        check($sformatf("row%0d_data_hold", ri), 32'(data_o), 32'(r.exp_data));
        check($sformatf("row%0d_err", ri), 32'(err_o), 32'(r.exp_err));
    endtask

    initial begin
        // en, valid, valid_at, skip_req, skip_at, idx, data, req, len, period, err
        rows[0]  = '{4'hF, 4'hF, 0, 1'b0, 0, 2'd0, 8'h0A, 1, 8, 0,  4'h0};
        rows[1]  = '{4'hF, 4'hF, 0, 1'b0, 0, 2'd1, 8'h32, 1, 8, 10, 4'h0};
        rows[2]  = '{4'hF, 4'hF, 0, 1'b0, 0, 2'd2, 8'hEC, 1, 8, 10, 4'h0};
        rows[3]  = '{4'hF, 4'hF, 0, 1'b0, 0, 2'd3, 8'hCE, 1, 8, 10, 4'h0};
        rows[4]  = '{4'hF, 4'hF, 0, 1'b0, 0, 2'd0, 8'h0A, 1, 8, 10, 4'h0};
        rows[5]  = '{4'hF, 4'hF, 0, 1'b0, 3, 2'd1, 8'h32, 1, 3, 10, 4'h0};
        rows[6]  = '{4'hF, 4'hF, 0, 1'b1, 0, 2'd2, 8'hEC, 1, 8, 5,  4'h0};
        rows[7]  = '{4'hA, 4'hF, 0, 1'b0, 0, 2'd3, 8'hCE, 1, 8, 10, 4'h0};
        rows[8]  = '{4'hA, 4'hF, 0, 1'b0, 0, 2'd1, 8'h32, 1, 8, 10, 4'h0};
        rows[9]  = '{4'hA, 4'hF, 0, 1'b0, 0, 2'd3, 8'hCE, 1, 8, 10, 4'h0};
        rows[10] = '{4'hF, 4'hF, 0, 1'b0, 0, 2'd1, 8'h32, 1, 8, 10, 4'h0};
        rows[11] = '{4'hF, 4'hD, 0, 1'b0, 0, 2'd2, 8'hEC, 1, 8, 10, 4'h0};
        rows[12] = '{4'hF, 4'hD, 0, 1'b0, 0, 2'd3, 8'hCE, 1, 8, 10, 4'h0};
        rows[13] = '{4'hF, 4'hD, 0, 1'b0, 0, 2'd0, 8'h0A, 1, 8, 10, 4'h0};
        rows[14] = '{4'hF, 4'hD, 0, 1'b0, 0, 2'd1, 8'h0A, 4, 0, 10, 4'h2};
        rows[15] = '{4'hF, 4'hD, 0, 1'b0, 0, 2'd2, 8'hEC, 1, 8, 5,  4'h2};
        rows[16] = '{4'hF, 4'hD, 0, 1'b0, 0, 2'd3, 8'hCE, 1, 8, 10, 4'h2};
        rows[17] = '{4'hF, 4'hF, 0, 1'b0, 0, 2'd0, 8'h0A, 1, 8, 10, 4'h2};
        rows[18] = '{4'hF, 4'hF, 0, 1'b0, 0, 2'd1, 8'h32, 1, 8, 10, 4'h0};
        rows[19] = '{4'hF, 4'hB, 4, 1'b0, 0, 2'd2, 8'hEC, 4, 8, 10, 4'h0};
        rows[20] = '{4'hF, 4'h7, 5, 1'b0, 0, 2'd3, 8'hEC, 4, 0, 13, 4'h8};
        rows[21] = '{4'hF, 4'hF, 0, 1'b0, 0, 2'd0, 8'h0A, 1, 8, 5,  4'h8};
        cur.len = 0;

        repeat (3) @(negedge clk_i);
        check("rst_ready", 32'(ch_ready_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_dvalid", 32'(data_valid_o), 0);
        check("rst_idx", 32'(ch_idx_o), 0);
        check("rst_err", 32'(err_o), 0);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        check("idle_no_en_ready", 32'(ch_ready_o), 0);

        ch_data_i  = 32'hCEEC_320A;
        en_i       = 4'hF;
        ch_valid_i = 4'hF;
        for (int i = 0; i < 22; i++) run_row(rows[i], i);

        // Mask everything off mid-SHOW: the dwell completes, then IDLE.
        begin
            int n;
            n = 0;
            while (ch_ready_o == '0 && n < 50) begin
                @(negedge clk_i);
                n++;
            end
            check("mask_idx", 32'(ch_idx_o), 1);
            sb_q.push_back('{2'd1, 8'h32, 8});
            for (int t = 0; t < 40; t++) begin
                @(negedge clk_i);
                if (t == 0) en_i = 4'h0;
                if (!data_valid_o) break;
            end
            check("mask_next_ready", 32'(ch_ready_o), 0);
            @(negedge clk_i);
            check("mask_idle_ready", 32'(ch_ready_o), 0);
            check("mask_idle_idx", 32'(ch_idx_o), 1);
            repeat (3) @(negedge clk_i);
            check("mask_idle_hold", 32'(ch_ready_o), 0);
        end

        // Current channel disabled while in REQ: no transfer, no error.
        en_i       = 4'hF;
        ch_valid_i = 4'hF;
        @(negedge clk_i);
        check("dis_req_ready", 32'(ch_ready_o), 32'(4'b0001));
        en_i = 4'b1110;
        @(negedge clk_i);
        check("dis_next_ready", 32'(ch_ready_o), 0);
        check("dis_next_dvalid", 32'(data_valid_o), 0);
        check("dis_next_err", 32'(err_o), 32'(4'h8));
        @(negedge clk_i);
        check("dis_req1_ready", 32'(ch_ready_o), 32'(4'b0010));
        sb_q.push_back('{2'd1, 8'h32, 8});
        for (int t = 0; t < 40; t++) begin
            @(negedge clk_i);
            if (!data_valid_o) break;
        end
        @(negedge clk_i);
        check("pre_rst_idx", 32'(ch_idx_o), 2);
        sb_q.push_back('{2'd2, 8'hEC, 0});

        // Reset during SHOW of channel 2.
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        en_i   = 4'hF;
        @(negedge clk_i);
        check("mid_rst_ready", 32'(ch_ready_o), 0);
        check("mid_rst_data", 32'(data_o), 0);
        check("mid_rst_dvalid", 32'(data_valid_o), 0);
        check("mid_rst_idx", 32'(ch_idx_o), 0);
        check("mid_rst_err", 32'(err_o), 0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready", 32'(ch_ready_o), 32'(4'b0001));
        check("post_rst_idx", 32'(ch_idx_o), 0);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_channel_scheduler.md
# display_channel_scheduler

Round-robin scheduler that shares the single 14-segment status display between up to four temperature sensor channels. It fetches one signed 8-bit reading per channel over a valid/ready handshake and holds it on the display input for a fixed dwell time. It then advances to the next enabled channel. It sits directly upstream of the status display FSM: `data_o` drives the display's `data_i`, and `ch_idx_o` drives the channel-number indicator.

## Interface
- `NUM_CH`, default 4: number of sensor channels, 2..4.
- `DWELL_CYCLES`, default 1000: cycles each accepted reading is held on `data_o`, ≥ 2.
- `TIMEOUT_CYCLES`, default 64: cycles to wait for `ch_valid_i` before a channel is declared missing, ≥ 1.
- `clk_i` in 1: the single clock. All logic is on the rising edge.
- `rst_ni` in 1: reset is synchronous and active-high.
- `en_i` in NUM_CH: per-channel enable mask. Disabled channels are never requested.
- `ch_valid_i` in NUM_CH: per-channel reading valid.
- `ch_data_i` in 8*NUM_CH: channel c occupies bits [8c+7:8c], two's complement °C.
- `skip_i` in 1: ends the current dwell early.
- `ch_ready_o` out NUM_CH: one-hot ready, asserted only for the channel being fetched.
- `data_o` out 8: registered reading for the display, signed.
- `data_valid_o` out 1: high while `data_o` holds a fresh reading (SHOW state).
- `ch_idx_o` out 2: index of the current channel.
- `err_o` out NUM_CH: sticky per-channel timeout flag.

## Operation
- **FSM states:** IDLE, REQ, SHOW, NEXT.
- **IDLE**
  - If `en_i` is zero, remain in IDLE.
  - Otherwise, load `ch_idx_o` with the lowest enabled index and go to REQ.
- **REQ**
  - Assert `ch_ready_o[ch_idx_o]` and clear the timeout counter on entry.
  - Transfer occurs on a cycle where `ch_ready_o[c]` and `ch_valid_i[c]` are both high. On that edge:
    - `data_o` ← `ch_data_i[c]`
    - `err_o[c]` ← 0
    - go to SHOW.
  - After `TIMEOUT_CYCLES` REQ cycles without a transfer:
    - `err_o[c]` ← 1
    - `data_o` is left unchanged
    - go to NEXT.
  - If `en_i[ch_idx_o]` is low in REQ, go to NEXT on the next edge with no transfer and no error.
  - `skip_i` is ignored in REQ.
- **SHOW**
  - `data_valid_o` = 1 and the dwell counter increments.
  - Leave for NEXT when the counter reaches `DWELL_CYCLES`-1, or on any cycle where `skip_i`=1, whichever comes first.
  - Changes to `en_i` during SHOW do not shorten the dwell.
- **NEXT** (exactly one cycle)
  - Choose the first enabled channel strictly after `ch_idx_o`, wrapping modulo NUM_CH. The current channel is considered last.
  - If one is found, update `ch_idx_o` and go to REQ.
  - If `en_i` is zero, go to IDLE. `ch_idx_o` holds its value.
- `data_o`, `data_valid_o`, `ch_ready_o` and `ch_idx_o` are all registered. Nothing combinational passes from inputs to outputs.
- The dwell and timeout counters are sized to `$clog2` of their parameter. They never wrap: each saturates at its terminal count, triggers its exit, and clears on state entry.

## Timing
- **Reset values:**
  - state = IDLE
  - `ch_ready_o` = 0, `data_o` = 8'h00, `data_valid_o` = 0
  - `ch_idx_o` = 0, `err_o` = 0
  - both counters = 0
- Reset wins over all other events in the same cycle. Reset asserted mid-REQ or mid-SHOW drops `ch_ready_o` and `data_valid_o` on that edge.
- **From IDLE:** the first `ch_ready_o` rises 1 cycle after leaving reset when `en_i` is non-zero.
- **Transfer:**
  - `data_o` and `data_valid_o` update on the edge that samples the transfer.
  - `ch_ready_o` drops on that same edge.
  - Exactly one transfer per REQ visit.
- **SHOW length:** exactly `DWELL_CYCLES` cycles without skip; minimum 1 cycle with skip.
- **Channel-to-channel period** (valid already high): 1 (REQ) + DWELL_CYCLES (SHOW) + 1 (NEXT).
- **Timeout:**
  - `err_o[c]` rises on the edge ending the `TIMEOUT_CYCLES`-th REQ cycle.
  - If `ch_valid_i` arrives on that last cycle, the transfer wins and no error is set.
- **Single enabled channel:** NEXT reselects the same channel; the channel is re-fetched every period.

## Test plan
Parameters for all scenarios: NUM_CH=4, DWELL_CYCLES=8, TIMEOUT_CYCLES=4.

1. **Round robin, all ready.** All valid held high, data 10/50/-20/-50, `en_i`=4'hF → `ch_idx_o` sequence 0,1,2,3,0. `data_o` follows 10, 50, 236, 206. Each SHOW is exactly 8 cycles; period is 10 cycles.
2. **Missing channel.** Only channel 1 never valid → after 4 REQ cycles `err_o`=4'b0010 and `data_o` keeps channel 0's value. Scheduler moves to channel 2. The next successful channel-1 transfer clears bit 1.
3. **Masked channels.** `en_i`=4'b1010 → only indices 1 and 3 are fetched. Switching to `en_i`=0 mid-SHOW completes the 8-cycle dwell, then NEXT goes to IDLE with `ch_ready_o`=0.
4. **Skip.** `skip_i` pulsed on the 3rd SHOW cycle → NEXT on the following cycle. `skip_i` held during REQ has no effect.
5. **Timeout boundary.** Valid arrives on REQ cycle 4 → transfer accepted and `err_o` stays 0. Valid arrives on cycle 5 → error set and channel skipped.
6. **Mid-operation reset.** `rst_ni`=1 during SHOW of channel 2 → next edge shows all outputs at reset values and state IDLE. After release, the first request goes to channel 0.
